// File: rtl/capture_readback.sv
// Read side of the sample-capture buffer: sweeps the BRAM read address over one
// record and streams each stored sample to a valid/ready sink.
//
// state | meaning
// IDLE  | waiting for a start edge while a full record is held
// ISSUE | read strobe high for the current address
// WAIT  | BRAM data arriving, latched into the output register
// SEND  | o_valid held until the sink accepts the sample
// DONE  | one-cycle completion pulse, address back to 0
module capture_readback #(
  parameter int NB_ADDR = 11,
  parameter int NB_DATA = 13,
  parameter int N_WORDS = 2046
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_mem_full,
  input  logic [NB_DATA-1:0] i_bram_data,
  input  logic               i_ready,
  output logic [NB_ADDR-1:0] o_read_addr,
  output logic               o_read_ena,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DONE} state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic               ena_q, ena_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_q, start_d;
  logic               start_edge;

  assign start_edge = i_start & ~start_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ena_d   = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    start_d = i_start;
    case (state_q)
      IDLE: begin
        addr_d  = '0;
        valid_d = 1'b0;
        if (start_edge && i_mem_full) begin
          state_d = ISSUE;
          ena_d   = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        data_d  = i_bram_data;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + NB_ADDR'(1);
            state_d = ISSUE;
            ena_d   = 1'b1;
          end
        end
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // start_q resets high so a switch already on at reset release is not an edge
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ena_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ena_q   <= ena_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  assign o_read_addr = addr_q;
  assign o_read_ena  = ena_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_capture_readback.sv
// Self-checking bench for capture_readback: a full-size instance (2046 words)
// and a 4-word instance, each fed by a one-cycle-latency BRAM model.
module tb_capture_readback;

  localparam int N_BIG = 2046;
  localparam int N_SMALL = 4;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start, mem_full, ready;
  logic [12:0] bram_data = '0;
  logic [10:0] read_addr;
  logic        read_ena, valid, busy, done;
  logic [12:0] data;

  logic        start4, mem_full4, ready4;
  logic [12:0] bram4 = '0;
  logic [10:0] addr4;
  logic        ena4, valid4, busy4, done4;
  logic [12:0] data4;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  always #5 clock = ~clock;

  capture_readback #(.NB_ADDR(11), .NB_DATA(13), .N_WORDS(N_BIG)) dut (
    .clock(clock), .i_reset(rst_n), .i_start(start), .i_mem_full(mem_full),
    .i_bram_data(bram_data), .i_ready(ready), .o_read_addr(read_addr),
    .o_read_ena(read_ena), .o_data(data), .o_valid(valid), .o_busy(busy),
    .o_done(done));

  capture_readback #(.NB_ADDR(11), .NB_DATA(13), .N_WORDS(N_SMALL)) dut4 (
    .clock(clock), .i_reset(rst_n), .i_start(start4), .i_mem_full(mem_full4),
    .i_bram_data(bram4), .i_ready(ready4), .o_read_addr(addr4),
    .o_read_ena(ena4), .o_data(data4), .o_valid(valid4), .o_busy(busy4),
    .o_done(done4));

  // BRAM contents: big buffer holds data=addr, small buffer holds addr+100
  always @(posedge clock) if (read_ena) bram_data <= 13'(read_addr);
  always @(posedge clock) if (ena4) bram4 <= 13'(addr4) + 13'd100;

  task automatic fill_big();
    exp_q.delete();
    for (int i = 0; i < N_BIG; i++) exp_q.push_back(13'(i));
  endtask

  task automatic test_reset();
    logic act;
    rst_n = 1'b0; start = 1'b1; mem_full = 1'b1; ready = 1'b1;
    start4 = 1'b1; mem_full4 = 1'b1; ready4 = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({read_addr, read_ena, data, valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%0d ena=%0b data=%0d valid=%0b busy=%0b done=%0b expected all 0",
               read_addr, read_ena, data, valid, busy, done);
    end
    checks++;
    if ({addr4, ena4, data4, valid4, busy4, done4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_small got addr=%0d ena=%0b data=%0d valid=%0b busy=%0b done=%0b expected all 0",
               addr4, ena4, data4, valid4, busy4, done4);
    end
    rst_n = 1'b1;
    act = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (read_ena || busy || ena4 || busy4) act = 1'b1;
    end
    checks++;
    if (act !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_level got activity=%0b expected 0", act);
    end
    start = 1'b0; start4 = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_full_dump();
    int cyc = 0, first_v = -1, done_c = -1, acc = 0;
    logic [10:0] max_a = '0;
    logic [12:0] e;
    fill_big();
    mem_full = 1'b1; ready = 1'b1;
    start = 1'b1;
    while (done_c < 0 && cyc < 3 * N_BIG + 50) begin
      @(negedge clock); cyc++;
      if (read_addr > max_a) max_a = read_addr;
      if (valid && first_v < 0) first_v = cyc;
      if (valid && ready) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1fff;
        if (data !== e) begin
          errors++;
          $display("FAIL full_dump_data got %0d expected %0d", data, e);
        end
        acc++;
      end
      if (done) done_c = cyc;
    end
    checks++;
    if (first_v != 3) begin
      errors++; $display("FAIL first_valid_latency got %0d expected 3", first_v);
    end
    checks++;
    if (done_c != 3 * N_BIG + 1) begin
      errors++; $display("FAIL done_latency got %0d expected %0d", done_c, 3 * N_BIG + 1);
    end
    checks++;
    if (acc != N_BIG || exp_q.size() != 0) begin
      errors++; $display("FAIL full_dump_count got %0d left %0d expected %0d left 0", acc, exp_q.size(), N_BIG);
    end
    checks++;
    if (max_a !== 11'(N_BIG - 1)) begin
      errors++; $display("FAIL full_dump_max_addr got %0d expected %0d", max_a, N_BIG - 1);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width got done=%0b busy=%0b expected 0 0", done, busy);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_backpressure();
    int cyc = 0, held = 0, acc = 0;
    logic seen_done = 1'b0;
    logic [12:0] e;
    fill_big();
    ready = 1'b1;
    start = 1'b1;
    while (!seen_done && cyc < 3 * N_BIG + 100) begin
      @(negedge clock); cyc++;
      if (held > 0 && held < 10) begin
        checks++;
        if (valid !== 1'b1 || data !== 13'd5 || read_ena !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_hold got valid=%0b data=%0d ena=%0b expected 1 5 0", valid, data, read_ena);
        end
        ready = 1'b0; held++;
      end else if (held == 0 && valid && data == 13'd5) begin
        ready = 1'b0; held = 1;
      end else begin
        ready = 1'b1;
      end
      if (valid && ready) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1fff;
        if (data !== e) begin
          errors++; $display("FAIL backpressure_data got %0d expected %0d", data, e);
        end
        acc++;
      end
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (held != 10 || acc != N_BIG || exp_q.size() != 0 || !seen_done) begin
      errors++;
      $display("FAIL backpressure_summary got held=%0d words=%0d left=%0d done=%0b expected 10 %0d 0 1",
               held, acc, exp_q.size(), seen_done, N_BIG);
    end
    ready = 1'b1; start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_ignore_edges();
    int cyc = 0, done_c = -1, acc = 0;
    logic act = 1'b0;
    logic [12:0] e;
    mem_full = 1'b0; start = 1'b1;
    repeat (15) begin
      @(negedge clock);
      if (busy || read_ena) act = 1'b1;
    end
    checks++;
    if (act !== 1'b0) begin
      errors++; $display("FAIL edge_without_full got activity=%0b expected 0", act);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);
    fill_big();
    mem_full = 1'b1; ready = 1'b1;
    start = 1'b1;
    while (done_c < 0 && cyc < 3 * N_BIG + 50) begin
      @(negedge clock); cyc++;
      if (cyc == 40) start = 1'b0;
      if (cyc == 45) start = 1'b1;
      if (cyc == 60) mem_full = 1'b0;
      if (valid && ready) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1fff;
        if (data !== e) begin
          errors++; $display("FAIL ignore_edges_data got %0d expected %0d", data, e);
        end
        acc++;
      end
      if (done) done_c = cyc;
    end
    checks++;
    if (done_c != 3 * N_BIG + 1 || acc != N_BIG || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_edges_summary got done_at=%0d words=%0d left=%0d expected %0d %0d 0",
               done_c, acc, exp_q.size(), 3 * N_BIG + 1, N_BIG);
    end
    act = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (busy || read_ena) act = 1'b1;
    end
    checks++;
    if (act !== 1'b0) begin
      errors++; $display("FAIL no_restart_after_done got activity=%0b expected 0", act);
    end
    mem_full = 1'b1; start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int cyc = 0, acc = 0, first_ra = -1;
    logic act = 1'b0;
    logic [12:0] e;
    fill_big();
    ready = 1'b1; start = 1'b1;
    while (!(acc == 100 && valid) && cyc < 400) begin
      @(negedge clock); cyc++;
      if (valid && ready && acc < 100) begin
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin
          errors++; $display("FAIL reset_mid_data got %0d expected %0d", data, e);
        end
        acc++;
      end
    end
    checks++;
    if (!(acc == 100 && valid)) begin
      errors++; $display("FAIL reset_mid_reach_word100 got words=%0d expected 100", acc);
    end
    rst_n = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({read_addr, read_ena, data, valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs got addr=%0d ena=%0b data=%0d valid=%0b busy=%0b done=%0b expected all 0",
               read_addr, read_ena, data, valid, busy, done);
    end
    repeat (3) begin
      @(negedge clock);
      if (done || busy) act = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) act = 1'b1;
    end
    checks++;
    if (act !== 1'b0) begin
      errors++; $display("FAIL reset_no_done got activity=%0b expected 0", act);
    end
    fill_big();
    acc = 0; cyc = 0;
    start = 1'b1;
    while (acc < 3 && cyc < 100) begin
      @(negedge clock); cyc++;
      if (read_ena && first_ra < 0) first_ra = int'(read_addr);
      if (valid && ready) begin
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin
          errors++; $display("FAIL restart_data got %0d expected %0d", data, e);
        end
        acc++;
      end
    end
    checks++;
    if (first_ra != 0 || acc != 3) begin
      errors++; $display("FAIL restart_addr got first_addr=%0d words=%0d expected 0 3", first_ra, acc);
    end
    rst_n = 1'b0; start = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_random_ready();
    for (int d = 0; d < 3; d++) begin
      int cyc = 0, acc = 0;
      logic seen_done = 1'b0, prev_hold = 1'b0;
      logic [12:0] prev_data = '0, e;
      logic [10:0] max_a = '0;
      exp_q.delete();
      for (int i = 0; i < N_SMALL; i++) exp_q.push_back(13'(i + 100));
      mem_full4 = 1'b1;
      start4 = 1'b1;
      while (!seen_done && cyc < 300) begin
        @(negedge clock); cyc++;
        if (addr4 > max_a) max_a = addr4;
        if (prev_hold) begin
          checks++;
          if (valid4 !== 1'b1 || data4 !== prev_data) begin
            errors++;
            $display("FAIL random_ready_stable got valid=%0b data=%0d expected 1 %0d", valid4, data4, prev_data);
          end
        end
        ready4 = 1'($urandom_range(0, 1));
        if (valid4 && ready4) begin
          checks++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1fff;
          if (data4 !== e) begin
            errors++; $display("FAIL random_ready_data got %0d expected %0d", data4, e);
          end
          acc++;
        end
        prev_hold = valid4 && !ready4;
        prev_data = data4;
        if (done4) seen_done = 1'b1;
      end
      checks++;
      if (acc != N_SMALL || exp_q.size() != 0 || !seen_done || max_a > 11'd3) begin
        errors++;
        $display("FAIL random_ready_summary got words=%0d left=%0d done=%0b max_addr=%0d expected 4 0 1 <=3",
                 acc, exp_q.size(), seen_done, max_a);
      end
      start4 = 1'b0;
      repeat (2) @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_ignore_edges();
    test_reset_mid();
    test_random_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
